time_set_controller: RTL
========================

# time_set_controller

Button-driven controller that sequences the time-of-day counter and the FND display path. Four push-buttons are debounced and turned into one-cycle press events. An FSM then either lets the counter run, or walks the user through editing hours and then minutes. Outputs are a counter run-enable, a one-cycle load strobe with the edited values, a display-mode select (hour:min vs sec:ms) and a per-digit blank mask that makes the field being edited blink. It sits between the board buttons and the time counter / display muxes.

## Interface
- DEBOUNCE_TICKS, default 20: consecutive stable ticks needed to accept a button level change.
- BLINK_TICKS, default 250: ticks per blink half-period.
- REPEAT_DELAY, default 500: ticks an up/down button must be held before auto-repeat starts (macro-dependent).
- REPEAT_RATE, default 100: ticks between auto-repeat events (macro-dependent).

- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_tick  in  1  1 kHz single-cycle enable; all tick counters advance only on i_tick.
- i_btn_set, i_btn_mode, i_btn_up, i_btn_down  in  1 each  raw asynchronous buttons, active-high.
- i_hour  in  6  current counter hour, 0..23.
- i_min  in  6  current counter minute, 0..59.
- o_run  out  1  counter enable.
- o_load  out  1  one-cycle strobe: counter loads o_hour/o_min and clears seconds and ms.
- o_hour  out  6  edited hour.
- o_min  out  6  edited minute.
- o_dispMode  out  1  0 = hour:min, 1 = sec:ms.
- o_blank  out  4  digit blank mask; bit3 = leftmost digit.
- o_state  out  2  FSM state, for debug.

## Operation
- Button path:
  - 2-flop synchronizer per button.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_TICKS consecutive ticks.
  - A press event is a 1-cycle pulse on the debounced rising edge.
- States:
  - RUN = 0, SET_HOUR = 1, SET_MIN = 2.
- RUN:
  - o_run = 1, o_blank = 0.
  - A mode event toggles o_dispMode.
  - A set event captures i_hour/i_min into o_hour/o_min and moves to SET_HOUR.
- SET_HOUR:
  - o_run = 0, o_dispMode forced to 0.
  - up: hour + 1, wrapping 23 -> 0.
  - down: hour - 1, wrapping 0 -> 23.
  - A set event moves to SET_MIN.
- SET_MIN:
  - Same as SET_HOUR, but up/down act on minutes with wrap 59 <-> 0.
  - A set event moves to RUN with o_load = 1 for that one transition cycle.
- mode events are ignored outside RUN. The pre-set o_dispMode value is restored on return to RUN.
- Blink:
  - A phase bit toggles every BLINK_TICKS ticks while not in RUN.
  - When phase = 1, o_blank = 4'b1100 in SET_HOUR and 4'b0011 in SET_MIN.
  - Any up/down event clears the phase and the blink counter, so the edited field shows immediately.
- Simultaneous events in the same cycle:
  - set has priority; up/down in that cycle are dropped.
  - up and down together: both ignored.
- Arithmetic is 6-bit with an explicit compare-and-wrap. Values never leave their legal range.

## Timing
- Reset values:
  - state RUN, o_run 1, o_load 0, o_hour 0, o_min 0, o_dispMode 0, o_blank 0.
  - Blink, debounce and repeat counters 0; debounced levels 0.
- Latency from a raw button edge to the press event: 2 cycles plus DEBOUNCE_TICKS ticks.
- All outputs are registered and update the cycle after the press event.
- o_load is high exactly 1 cycle, in the same cycle o_state returns to RUN and o_run rises.
- Reset mid-edit: return to RUN immediately, no o_load, edits are discarded.

## Configuration
- TIME_SET_AUTOREPEAT_EN defined:
  - In SET states, a held up/down button produces its first event on press.
  - After REPEAT_DELAY ticks of continuous hold, further events follow every REPEAT_RATE ticks until release.
  - The repeat counter resets on release or on a state change.
- Not defined: exactly one event per press. REPEAT_* are unused.

## Structure
- Shared package time_clock_pkg holds:
  - the state enum (RUN/SET_HOUR/SET_MIN, 2 bits);
  - HOUR_MAX = 23, MIN_MAX = 59;
  - the blank-mask constants BLANK_HOUR = 4'b1100, BLANK_MIN = 4'b0011.
- Sub-module btn_debounce (synchronizer + debounce counter + rising-edge pulse), instantiated 4 times.
- FSM, edit registers, blink and auto-repeat logic live in the top.

## Test plan
- Reset released, no buttons -> o_run = 1, o_state = 0, o_blank = 0 for 10k cycles.
- Glitch: set high for 10 ticks, then low -> no state change. Set high for 25 ticks -> SET_HOUR, o_hour = i_hour.
- Hour edit: i_hour = 23, enter SET_HOUR, 1 up -> o_hour = 0. Then 2 down -> 22. Then set, set -> o_load pulses 1 cycle with o_hour = 22, o_run = 1.
- Minute wrap: in SET_MIN with o_min = 59, up -> 0. mode press -> o_dispMode unchanged. Blink: o_blank alternates 0000/0011 every 250 ticks, and an up press forces 0000.
- Same-cycle set + up in SET_HOUR -> SET_MIN, o_hour unchanged. Reset asserted in SET_MIN -> RUN, o_load never asserted.
- With TIME_SET_AUTOREPEAT_EN: hold up 1000 ticks in SET_MIN from 0 -> events at 0, 500, 600, ..., 1000, so o_min = 7.

Source files
------------

// File: rtl/time_clock_pkg.sv
// time_clock_pkg: shared FSM states, field limits, blank masks and the
// wrap-around increment/decrement helpers for the time-set controller.
package time_clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    localparam logic [5:0] HOUR_MAX   = 6'd23;
    localparam logic [5:0] MIN_MAX    = 6'd59;
    localparam logic [3:0] BLANK_HOUR = 4'b1100;
    localparam logic [3:0] BLANK_MIN  = 4'b0011;

    // Increment with explicit compare-and-wrap; anything at/above max goes to 0.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

    // Decrement with explicit compare-and-wrap; 0 (or out-of-range) goes to max.
    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
        return ((v == 6'd0) || (v > max)) ? max : v - 6'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, tick-based debounce counter and a
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], i_btn};
    end

    // Accept a new level only after it has differed for DEBOUNCE_TICKS consecutive ticks.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync[1] == r_level) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            if (r_cnt == CW'(DEBOUNCE_TICKS - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_level_d <= 1'b0;
        else          r_level_d <= r_level;
    end

    assign o_level = r_level;
    assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: debounced buttons drive a RUN / SET_HOUR / SET_MIN FSM
// that edits hour and minute, blinks the field under edit and strobes a load.
// Optional hold-to-repeat on up/down: define TIME_SET_AUTOREPEAT_EN.
module time_set_controller
    import time_clock_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int BLINK_TICKS    = 250,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_btn_set,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic [5:0] i_hour,
    input  logic [5:0] i_min,
    output logic       o_run,
    output logic       o_load,
    output logic [5:0] o_hour,
    output logic [5:0] o_min,
    output logic       o_dispMode,
    output logic [3:0] o_blank,
    output logic [1:0] o_state
);
    localparam int BTN_SET  = 0;
    localparam int BTN_MODE = 1;
    localparam int BTN_UP   = 2;
    localparam int BTN_DOWN = 3;
    localparam int BW       = $clog2(BLINK_TICKS + 1);

    logic [3:0] w_raw, w_level, w_press;
    logic [1:0] w_rep;   // [0] = up repeat, [1] = down repeat

    assign w_raw = {i_btn_down, i_btn_up, i_btn_mode, i_btn_set};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_tick  (i_tick),
            .i_btn   (w_raw[g]),
            .o_level (w_level[g]),
            .o_press (w_press[g])
        );
    end

    state_t        r_state, w_next_state;
    logic [5:0]    r_hour, r_min, w_next_hour, w_next_min;
    logic          r_disp, w_next_disp;       // user's chosen mode, kept across edits
    logic          r_disp_out, r_run, r_load, w_next_load;
    logic [3:0]    r_blank, w_next_blank;
    logic          r_phase, w_next_phase;
    logic [BW-1:0] r_blink_cnt, w_next_blink_cnt;
    logic          w_set, w_mode, w_up, w_dn, w_edit_up, w_edit_dn;

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [1:0][RW-1:0] r_rep_cnt;
    logic [1:0]         r_rep_armed;
    logic [1:0]         w_hold;
    logic               w_unused;

    assign w_hold   = w_level[BTN_DOWN:BTN_UP];
    assign w_unused = ^w_level[BTN_MODE:BTN_SET];

    // Repeat fires after REPEAT_DELAY ticks of hold, then every REPEAT_RATE ticks.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_rep[i] = i_tick && w_hold[i] && (r_state != RUN) &&
                       (r_rep_armed[i] ? (r_rep_cnt[i] == RW'(REPEAT_RATE - 1))
                                       : (r_rep_cnt[i] == RW'(REPEAT_DELAY - 1)));
        end
    end

    // Hold-time counters; cleared on release, outside SET states and on any state change.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!w_hold[i] || (r_state == RUN) || (w_next_state != r_state)) begin
                    r_rep_cnt[i]   <= '0;
                    r_rep_armed[i] <= 1'b0;
                end else if (w_rep[i]) begin
                    r_rep_cnt[i]   <= '0;
                    r_rep_armed[i] <= 1'b1;
                end else if (i_tick) begin
                    r_rep_cnt[i] <= r_rep_cnt[i] + RW'(1);
                end
            end
        end
    end
`else
    logic w_unused;
    assign w_rep    = 2'b00;
    assign w_unused = ^{w_level, REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

    assign w_set     = w_press[BTN_SET];
    assign w_mode    = w_press[BTN_MODE];
    assign w_up      = w_press[BTN_UP]   | w_rep[0];
    assign w_dn      = w_press[BTN_DOWN] | w_rep[1];
    // set wins over up/down; up and down together cancel
    assign w_edit_up = w_up & ~w_dn & ~w_set;
    assign w_edit_dn = w_dn & ~w_up & ~w_set;

    // Next-state, edit values, blink and output decode.
    always_comb begin
        w_next_state     = r_state;
        w_next_hour      = r_hour;
        w_next_min       = r_min;
        w_next_disp      = r_disp;
        w_next_load      = 1'b0;
        w_next_phase     = r_phase;
        w_next_blink_cnt = r_blink_cnt;
        w_next_blank     = 4'b0000;

        case (r_state)
            RUN: begin
                if (w_set) begin
                    w_next_state = SET_HOUR;
                    w_next_hour  = i_hour;
                    w_next_min   = i_min;
                end else if (w_mode) begin
                    w_next_disp = ~r_disp;
                end
            end
            SET_HOUR: begin
                if (w_set)          w_next_state = SET_MIN;
                else if (w_edit_up) w_next_hour  = wrap_inc(r_hour, HOUR_MAX);
                else if (w_edit_dn) w_next_hour  = wrap_dec(r_hour, HOUR_MAX);
            end
            SET_MIN: begin
                if (w_set) begin
                    w_next_state = RUN;
                    w_next_load  = 1'b1;
                end else if (w_edit_up) begin
                    w_next_min = wrap_inc(r_min, MIN_MAX);
                end else if (w_edit_dn) begin
                    w_next_min = wrap_dec(r_min, MIN_MAX);
                end
            end
            default: w_next_state = RUN;
        endcase

        // An edit restarts the blink so the new value is visible at once.
        if ((w_next_state == RUN) || (w_next_state != r_state) || w_edit_up || w_edit_dn) begin
            w_next_phase     = 1'b0;
            w_next_blink_cnt = '0;
        end else if (i_tick) begin
            if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
                w_next_phase     = ~r_phase;
                w_next_blink_cnt = '0;
            end else begin
                w_next_blink_cnt = r_blink_cnt + BW'(1);
            end
        end

        if (w_next_phase) begin
            if (w_next_state == SET_HOUR)     w_next_blank = BLANK_HOUR;
            else if (w_next_state == SET_MIN) w_next_blank = BLANK_MIN;
        end
    end

    // Register state and every output.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= RUN;
            r_hour      <= 6'd0;
            r_min       <= 6'd0;
            r_disp      <= 1'b0;
            r_disp_out  <= 1'b0;
            r_run       <= 1'b1;
            r_load      <= 1'b0;
            r_blank     <= 4'b0000;
            r_phase     <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_hour      <= w_next_hour;
            r_min       <= w_next_min;
            r_disp      <= w_next_disp;
            r_disp_out  <= (w_next_state == RUN) ? w_next_disp : 1'b0;
            r_run       <= (w_next_state == RUN);
            r_load      <= w_next_load;
            r_blank     <= w_next_blank;
            r_phase     <= w_next_phase;
            r_blink_cnt <= w_next_blink_cnt;
        end
    end

    assign o_state    = r_state;
    assign o_hour     = r_hour;
    assign o_min      = r_min;
    assign o_dispMode = r_disp_out;
    assign o_run      = r_run;
    assign o_load     = r_load;
    assign o_blank    = r_blank;

endmodule
